// File: rtl/kbd_input_ctrl_pkg.sv
// Shared scancode constants, decoder state type and key-map helper for the
// PS/2 key-pulse producer.
package kbd_input_ctrl_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Bit positions in the held mask and pulse vector {drop,rotate,down,right,left}
    localparam int K_LEFT   = 0;
    localparam int K_RIGHT  = 1;
    localparam int K_DOWN   = 2;
    localparam int K_ROTATE = 3;
    localparam int K_DROP   = 4;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kbd_state_t;

    // One-hot key for a final byte; arrows need the E0 prefix, space must not have it.
    function automatic logic [4:0] key_mask(input logic [7:0] code, input logic ext);
        logic [4:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_LEFT:  m[K_LEFT]   = 1'b1;
                SC_RIGHT: m[K_RIGHT]  = 1'b1;
                SC_DOWN:  m[K_DOWN]   = 1'b1;
                SC_UP:    m[K_ROTATE] = 1'b1;
                default:  m = '0;
            endcase
        end else if (code == SC_SPACE) begin
            m[K_DROP] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/kbd_input_ctrl_key_repeat_timer.sv
// Delayed auto-shift timer: after restart, fires once DAS_CYCLES later, then
// every ARR_CYCLES while run stays high. restart and !run both override a fire.
module key_repeat_timer #(
    parameter int DAS_CYCLES = 17_000_000,
    parameter int ARR_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic fire
);
    localparam int W = $clog2(DAS_CYCLES + 1);
    localparam logic [W-1:0] DAS_LAST = W'(DAS_CYCLES - 1);
    localparam logic [W-1:0] ARR_LAST = W'(ARR_CYCLES - 1);

    if (!(DAS_CYCLES >= ARR_CYCLES && ARR_CYCLES >= 2)) begin : g_bad_params
        $error("key_repeat_timer: need DAS_CYCLES >= ARR_CYCLES >= 2");
    end

    logic [W-1:0] cnt;
    logic         running;
    logic         in_das;

    assign fire = running && run && !restart && (cnt == (in_das ? DAS_LAST : ARR_LAST));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
            in_das  <= 1'b1;
        end else if (restart) begin
            cnt     <= '0;
            running <= 1'b1;
            in_das  <= 1'b1;
        end else if (!run) begin
            cnt     <= '0;
            running <= 1'b0;
            in_das  <= 1'b1;
        end else if (fire) begin
            cnt     <= '0;
            in_das  <= 1'b0;
        end else if (running) begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kbd_input_ctrl.sv
// PS/2 set-2 scancode decoder producing one-cycle game key pulses with
// DAS/ARR auto-repeat on the horizontal (last-pressed wins) and down keys.
module kbd_input_ctrl
    import kbd_input_ctrl_pkg::*;
#(
    parameter int DAS_CYCLES = 17_000_000,
    parameter int ARR_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop,
    output logic [4:0] held
);
    kbd_state_t state, state_next;
    logic       is_final, is_ext, is_brk;
    logic [4:0] ev, make_new, brk_hit, held_q, held_next;
    logic [4:0] pulse_q, pulse_next;
    logic       dir_right_q, dir_right_next, switch_dir;
    logic       h_restart, h_run, h_fire;
    logic       d_restart, d_run, d_fire;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        is_final   = 1'b0;
        is_ext     = 1'b0;
        is_brk     = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == SC_EXT)      state_next = EXT;
                    else if (scan_code == SC_BRK) state_next = BRK;
                    else                          is_final   = 1'b1;
                end
                EXT: begin
                    if (scan_code == SC_BRK) state_next = EXT_BRK;
                    else begin
                        is_final = 1'b1;
                        is_ext   = 1'b1;
                    end
                end
                BRK: begin
                    is_final = 1'b1;
                    is_brk   = 1'b1;
                end
                EXT_BRK: begin
                    is_final = 1'b1;
                    is_ext   = 1'b1;
                    is_brk   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
            if (is_final) state_next = IDLE;
        end
    end

    // Typematic makes of held keys and breaks of released keys drop out here.
    always_comb begin
        ev        = is_final ? key_mask(scan_code, is_ext) : '0;
        make_new  = is_brk ? '0 : (ev & ~held_q);
        brk_hit   = is_brk ? (ev & held_q) : '0;
        held_next = (held_q | make_new) & ~brk_hit;

        switch_dir = dir_right_q ? (brk_hit[K_RIGHT] && held_next[K_LEFT])
                                 : (brk_hit[K_LEFT]  && held_next[K_RIGHT]);
        dir_right_next = dir_right_q;
        if (make_new[K_RIGHT])     dir_right_next = 1'b1;
        else if (make_new[K_LEFT]) dir_right_next = 1'b0;
        else if (switch_dir)       dir_right_next = !dir_right_q;

        h_restart = make_new[K_LEFT] || make_new[K_RIGHT] || switch_dir;
        h_run     = held_next[K_LEFT] || held_next[K_RIGHT];
        d_restart = make_new[K_DOWN];
        d_run     = held_next[K_DOWN];

        // A fire never coincides with a restart, so the current direction is the one to repeat.
        pulse_next          = make_new;
        pulse_next[K_LEFT]  = make_new[K_LEFT]  || (h_fire && !dir_right_q);
        pulse_next[K_RIGHT] = make_new[K_RIGHT] || (h_fire && dir_right_q);
        pulse_next[K_DOWN]  = make_new[K_DOWN]  || d_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            held_q      <= '0;
            pulse_q     <= '0;
            dir_right_q <= 1'b0;
        end else begin
            state       <= state_next;
            held_q      <= held_next;
            pulse_q     <= pulse_next;
            dir_right_q <= dir_right_next;
        end
    end

    key_repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_h_timer (
        .clk(clk), .rst(rst), .restart(h_restart), .run(h_run), .fire(h_fire)
    );

    key_repeat_timer #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_d_timer (
        .clk(clk), .rst(rst), .restart(d_restart), .run(d_run), .fire(d_fire)
    );

    assign key_left   = pulse_q[K_LEFT];
    assign key_right  = pulse_q[K_RIGHT];
    assign key_down   = pulse_q[K_DOWN];
    assign key_rotate = pulse_q[K_ROTATE];
    assign key_drop   = pulse_q[K_DROP];
    assign held       = held_q;

endmodule

// File: tb/tb_kbd_input_ctrl.sv
// Directed and randomized scancode streams against a time-stamped behavioural
// model of key pulses and DAS/ARR repeat deadlines.
module tb_kbd_input_ctrl;
    localparam int DAS = 20;
    localparam int ARR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       key_left, key_right, key_down, key_rotate, key_drop;
    logic [4:0] held;

    kbd_input_ctrl #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
        .key_left(key_left), .key_right(key_right), .key_down(key_down),
        .key_rotate(key_rotate), .key_drop(key_drop), .held(held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (pulses{drop,rot,down,right,left} held)", tag, got, exp);
        end
    endtask

    // Model: key state as a bit array, repeat timers as absolute due-cycle numbers.
    int       n = 0;
    bit [4:0] m_held = '0;
    bit       m_ext = 0, m_brk = 0, m_dir_right = 0;
    bit       h_on = 0, d_on = 0;
    int       h_due = 0, d_due = 0;
    int       left_seen = 0;

    function automatic int key_of(input logic [7:0] c, input bit ext);
        if (ext) begin
            if (c == 8'h6B) return 0;
            if (c == 8'h74) return 1;
            if (c == 8'h72) return 2;
            if (c == 8'h75) return 3;
            return -1;
        end
        return (c == 8'h29) ? 4 : -1;
    endfunction

    task automatic step(input logic v, input logic [7:0] c, input logic r, input string tag);
        bit [4:0] exp_p;
        int       k;
        bit       is_brk;
        rst        = r;
        scan_valid = v;
        scan_code  = c;
        n++;
        exp_p = '0;
        if (r) begin
            m_held = '0; m_ext = 0; m_brk = 0; h_on = 0; d_on = 0; m_dir_right = 0;
        end else begin
            if (v) begin
                if (c == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
                else if (c == 8'hF0 && !m_brk) m_brk = 1;
                else begin
                    k = key_of(c, m_ext);
                    is_brk = m_brk;
                    m_ext = 0;
                    m_brk = 0;
                    if (k >= 0 && !is_brk && !m_held[k]) begin
                        m_held[k] = 1;
                        exp_p[k] = 1;
                        if (k < 2) begin m_dir_right = (k == 1); h_on = 1; h_due = n + DAS; end
                        if (k == 2) begin d_on = 1; d_due = n + DAS; end
                    end else if (k >= 0 && is_brk && m_held[k]) begin
                        m_held[k] = 0;
                        if (k < 2 && ((k == 1) == m_dir_right)) begin
                            if (m_held[1 - k]) begin m_dir_right = !m_dir_right; h_due = n + DAS; end
                            else h_on = 0;
                        end
                        if (k == 2) d_on = 0;
                    end
                end
            end
            if (h_on && h_due == n) begin
                exp_p[m_dir_right ? 1 : 0] = 1;
                h_due = n + ARR;
            end
            if (d_on && d_due == n) begin
                exp_p[2] = 1;
                d_due = n + ARR;
            end
        end
        @(posedge clk);
        #1;
        left_seen += int'(key_left);
        check(tag, {key_drop, key_rotate, key_down, key_right, key_left, held}, {exp_p, m_held});
        scan_valid = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input string tag);
        step(1'b1, c, 1'b0, tag);
    endtask

    task automatic idle(input int k, input string tag);
        for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0, tag);
    endtask

    logic [7:0] key_code [5] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29};

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "reset");

        send(8'hE0, "tap"); send(8'h75, "tap"); idle(3, "tap");
        send(8'hE0, "tap_brk"); send(8'hF0, "tap_brk"); send(8'h75, "tap_brk"); idle(5, "tap_idle");

        left_seen = 0;
        send(8'hE0, "das");
        left_seen = 0;
        send(8'h6B, "das"); idle(39, "das");
        check("das_count", 10'(left_seen), 10'd5);
        send(8'hE0, "das_brk"); send(8'hF0, "das_brk"); send(8'h6B, "das_brk"); idle(30, "das_stop");

        for (int i = 0; i < 4; i++) begin send(8'h29, "typematic"); idle(2, "typematic"); end
        send(8'hF0, "drop_brk"); send(8'h29, "drop_brk"); send(8'h29, "drop_again"); idle(3, "drop_again");
        send(8'hF0, "drop_brk"); send(8'h29, "drop_brk");

        send(8'hE0, "lpw"); send(8'h6B, "lpw"); idle(10, "lpw_left");
        send(8'hE0, "lpw"); send(8'h74, "lpw"); idle(30, "lpw_right");
        send(8'hE0, "lpw"); send(8'hF0, "lpw"); send(8'h74, "lpw"); idle(30, "lpw_resume");
        send(8'hE0, "lpw"); send(8'hF0, "lpw"); send(8'h6B, "lpw"); idle(5, "lpw_end");

        send(8'hE0, "down"); send(8'h72, "down"); idle(32, "down_rep");
        send(8'hE0, "down"); send(8'hF0, "down"); send(8'h72, "down"); idle(10, "down_stop");

        send(8'h6B, "garbage"); idle(2, "garbage");
        send(8'hE0, "mid_reset"); step(1'b0, 8'h00, 1'b1, "mid_reset");
        send(8'h75, "mid_reset"); idle(3, "mid_reset");

        for (int a = 0; a < 250; a++) begin
            int sel, key;
            sel = int'($urandom_range(0, 19));
            key = int'($urandom_range(0, 4));
            if (sel == 0) step(1'b0, 8'h00, 1'b1, "rand_rst");
            else if (sel < 3) send(8'($urandom), "rand_byte");
            else begin
                if (key < 4) send(8'hE0, "rand_seq");
                if (sel < 9) send(8'hF0, "rand_seq");
                send(key_code[key], "rand_seq");
            end
            idle(int'($urandom_range(0, 30)), "rand_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
